traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Timed phase controller for a two-street intersection (street A, street B).
//   Sequences green, yellow, all-red and the other street's green from the
//   ta/tb traffic sensors. Enforces minimum and maximum green times and fixed
//   yellow and all-red clearance intervals.
//   It drives the la/lb light encodings that the intersection light FSM
//   consumes. It is the scheduler that shares the crossing between the streets.
// PARAMETERS
//   GREEN_MIN  5   min green cycles per street (>=1)
//   GREEN_MAX  20  max green cycles while the other street waits (>=GREEN_MIN)
//   YELLOW_CYC 3   yellow duration in cycles (>=1)
//   ALLRED_CYC 2   all-red clearance duration in cycles (>=1)
//   CNT_W      8   phase timer width; all durations must be <= 2**CNT_W-1
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   ta         in   1  traffic present on street A (sampled each edge)
//   tb         in   1  traffic present on street B (sampled each edge)
//   emg_req    in   1  emergency preempt request (used only with macro)
//   emg_dir    in   1  preempt direction: 0=A, 1=B
//   la         out  2  street A light: 00 green, 01 yellow, 10 red
//   lb         out  2  street B light, same encoding
//   phase      out  3  current phase_t value, for debug/status
//   emg_active out  1  preempt currently forcing the sequence
// BEHAVIOUR
//   Moore FSM. la/lb/phase decode combinationally from the state register.
//   Phases, in cycle order:
//     A_GRN -> A_YEL -> RED_AB -> B_GRN -> B_YEL -> RED_BA -> A_GRN
//   Lights per phase:
//     A_GRN: la green, lb red.   A_YEL: la yellow, lb red.
//     B_GRN: la red, lb green.   B_YEL: la red, lb yellow.
//     RED_AB, RED_BA: both red.
//   Reset (async, immediate, no clock needed):
//     state=A_GRN, cnt=0, la=00, lb=10, phase=0, emg_active=0.
//   cnt: phase timer. Clears to 0 on the edge that changes phase, otherwise
//     increments. Saturates at all-ones and never wraps.
//   A_GRN exit to A_YEL when (cnt>=GREEN_MIN-1) && tb && (!ta || cnt>=GREEN_MAX-1).
//     So green lasts >= GREEN_MIN cycles and is held indefinitely while tb=0.
//   B_GRN: the mirror rule, with ta and tb swapped.
//   Yellow exits when cnt==YELLOW_CYC-1. All-red exits when cnt==ALLRED_CYC-1.
//   Sensors are ignored in the yellow and all-red phases.
//   Simultaneous ta=tb=1: alternate, each green lasting exactly GREEN_MAX cycles.
//   No state ever shows green on both streets. Illegal state encodings
//   recover to RED_BA.
// CONFIGURATION
//   EMERGENCY_PREEMPT_EN defined:
//     - emg_req=1 with the direction currently green: hold that green and
//       ignore GREEN_MAX.
//     - emg_req=1 with the other direction green: go to yellow on the next
//       edge, ignoring GREEN_MIN.
//     - In yellow or all-red: timing is unchanged, then the preempted
//       direction's green is taken.
//     - emg_active=1 while emg_req is affecting the sequence.
//   EMERGENCY_PREEMPT_EN not defined:
//     - emg_req and emg_dir are ignored, and emg_active is tied to 0.
//     - The port list is identical in both builds.
// STRUCTURE
//   Package traffic_pkg:
//     - light_t enum {GREEN=2'b00, YELLOW=2'b01, RED=2'b10}
//     - phase_t enum {A_GRN, A_YEL, RED_AB, B_GRN, B_YEL, RED_BA}
//   Sub-module phase_timer:
//     - CNT_W saturating counter with a synchronous clear input.
//     - Async reset to 0.
//   FSM next-state and light decode stay in this module.
// TESTING (defaults)
//   1. reset=1 for 10 time units, no clock edges -> la=00, lb=10, phase=A_GRN,
//      emg_active=0.
//   2. Release reset, ta=0 tb=1 -> A green 5 cycles, la=01 for 3, both 10 for 2,
//      lb=00 on cycle 10.
//   3. ta=1 tb=1 held -> A green 20, yellow 3, all-red 2, B green 20, repeating.
//   4. ta=1 tb=0 for 100 cycles -> la=00, lb=10 throughout, cnt saturates and
//      does not wrap (check CNT_W=4 too).
//   5. reset pulsed mid A_YEL between edges -> la=00, lb=10 immediately.
//      Step 2 timing restarts from 0.
//   6. Macro on: A_GRN cnt=1, emg_req=1 emg_dir=1 -> A_YEL next edge, B green
//      held while emg_req=1 with ta=1. Macro off: the same stimulus gives
//      normal timing and emg_active=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the two-street traffic phase sequencer.
package traffic_pkg;

  // Per-street light encoding driven to the intersection light FSM.
  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  // Phases in cycle order; the numeric value is exported on the phase output.
  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase timer: counts cycles spent in the current phase, clears on
// request and holds at all-ones instead of wrapping.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed phase controller for a two-street intersection.
// Optional emergency preemption is compiled in with EMERGENCY_PREEMPT_EN;
// without it emg_req/emg_dir are ignored and emg_active is tied low.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN  = 5,
  parameter int unsigned GREEN_MAX  = 20,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic [2:0] phase,
  output logic       emg_active
);

  localparam logic [CNT_W-1:0] GMinM1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMaxM1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YelM1  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RedM1  = CNT_W'(ALLRED_CYC - 1);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             emg_a, emg_b;
  logic             a_grn_exit, b_grn_exit;

`ifdef EMERGENCY_PREEMPT_EN
  assign emg_a      = emg_req & ~emg_dir;
  assign emg_b      = emg_req & emg_dir;
  assign emg_active = emg_req;
`else
  logic unused_emg;
  assign unused_emg = emg_req ^ emg_dir;
  assign emg_a      = 1'b0;
  assign emg_b      = 1'b0;
  assign emg_active = 1'b0;
`endif

  // A preempt toward the other street forces an exit; one toward this street
  // holds green regardless of GREEN_MAX.
  assign a_grn_exit = emg_b |
                      (~emg_a & (cnt >= GMinM1) & tb & (~ta | (cnt >= GMaxM1)));
  assign b_grn_exit = emg_a |
                      (~emg_b & (cnt >= GMinM1) & ta & (~tb | (cnt >= GMaxM1)));

  // Timer restarts on every phase change.
  assign cnt_clr = (state_d != state_q);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= A_GRN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-phase selection; unreachable encodings fall into the all-red before A.
  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GRN:   if (a_grn_exit) state_d = A_YEL;
      A_YEL:   if (cnt == YelM1) state_d = RED_AB;
      RED_AB:  if (cnt == RedM1) state_d = emg_a ? A_GRN : B_GRN;
      B_GRN:   if (b_grn_exit) state_d = B_YEL;
      B_YEL:   if (cnt == YelM1) state_d = RED_BA;
      RED_BA:  if (cnt == RedM1) state_d = emg_b ? B_GRN : A_GRN;
      default: state_d = RED_BA;
    endcase
  end

  // Light decode from the phase register; anything unexpected shows all red.
  always_comb begin
    la    = RED;
    lb    = RED;
    phase = state_q;
    case (state_q)
      A_GRN:   la = GREEN;
      A_YEL:   la = YELLOW;
      B_GRN:   lb = GREEN;
      B_YEL:   lb = YELLOW;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomized bench for traffic_phase_sequencer: two instances (default timing
// and a narrow 4-bit timer) driven in parallel against a phase/elapsed model.
module tb_traffic_phase_sequencer;

`ifdef EMERGENCY_PREEMPT_EN
  localparam bit EmgEn = 1'b1;
`else
  localparam bit EmgEn = 1'b0;
`endif

  logic       clk = 1'b0;
  bit         clk_run = 1'b0;
  logic       reset, sens_a, sens_b, emg_req, emg_dir;
  logic [1:0] la0, lb0, la1, lb1;
  logic [2:0] ph0, ph1;
  logic       ea0, ea1;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_sequencer u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .ta         (sens_a),
    .tb         (sens_b),
    .emg_req    (emg_req),
    .emg_dir    (emg_dir),
    .la         (la0),
    .lb         (lb0),
    .phase      (ph0),
    .emg_active (ea0)
  );

  traffic_phase_sequencer #(
    .GREEN_MIN  (3),
    .GREEN_MAX  (10),
    .YELLOW_CYC (2),
    .ALLRED_CYC (1),
    .CNT_W      (4)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .ta         (sens_a),
    .tb         (sens_b),
    .emg_req    (emg_req),
    .emg_dir    (emg_dir),
    .la         (la1),
    .lb         (lb1),
    .phase      (ph1),
    .emg_active (ea1)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  // Reference model: phase index 0..5 plus unbounded cycles spent in it.
  int gmin_p[2] = '{5, 3};
  int gmax_p[2] = '{20, 10};
  int yel_p[2]  = '{3, 2};
  int red_p[2]  = '{2, 1};
  int la_tab[6] = '{0, 1, 2, 2, 2, 2};
  int lb_tab[6] = '{2, 2, 2, 0, 1, 2};
  int m_ph[2];
  int m_el[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0;
      m_el[k] = 0;
    end
  endfunction

  function automatic void model_step(input bit a, input bit b, input bit er, input bit ed);
    bit pre_a = EmgEn && er && !ed;
    bit pre_b = EmgEn && er && ed;
    for (int k = 0; k < 2; k++) begin
      int e  = m_el[k];
      int nx = m_ph[k];
      case (m_ph[k])
        0: if (pre_b || (!pre_a && e >= gmin_p[k] - 1 && b && (!a || e >= gmax_p[k] - 1))) nx = 1;
        1: if (e == yel_p[k] - 1) nx = 2;
        2: if (e == red_p[k] - 1) nx = pre_a ? 0 : 3;
        3: if (pre_a || (!pre_b && e >= gmin_p[k] - 1 && a && (!b || e >= gmax_p[k] - 1))) nx = 4;
        4: if (e == yel_p[k] - 1) nx = 5;
        default: if (e == red_p[k] - 1) nx = pre_b ? 3 : 0;
      endcase
      if (nx != m_ph[k]) begin
        m_ph[k] = nx;
        m_el[k] = 0;
      end else begin
        m_el[k] = e + 1;
      end
    end
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int ea_exp = (EmgEn && emg_req) ? 1 : 0;
    check_eq("la0", int'(la0), la_tab[m_ph[0]]);
    check_eq("lb0", int'(lb0), lb_tab[m_ph[0]]);
    check_eq("phase0", int'(ph0), m_ph[0]);
    check_eq("emg_active0", int'(ea0), ea_exp);
    check_eq("la1", int'(la1), la_tab[m_ph[1]]);
    check_eq("lb1", int'(lb1), lb_tab[m_ph[1]]);
    check_eq("phase1", int'(ph1), m_ph[1]);
    check_eq("emg_active1", int'(ea1), ea_exp);
  endtask

  // Apply inputs, let one rising edge pass, then compare just after it.
  task automatic cycle(input bit a, input bit b, input bit er, input bit ed);
    sens_a  = a;
    sens_b  = b;
    emg_req = er;
    emg_dir = ed;
    @(posedge clk);
    model_step(a, b, er, ed);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must react at once.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset   = 1'b1;
    sens_a  = 1'b0;
    sens_b  = 1'b0;
    emg_req = 1'b0;
    emg_dir = 1'b0;
    model_reset();
    #10;
    check_all();
    reset   = 1'b0;
    clk_run = 1'b1;

    // B waiting, A idle: minimum green, yellow, all-red, then B green.
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during A yellow, then the same sequence from scratch.
    reset_pulse();
    guard = 0;
    while (m_ph[0] != 1 && guard < 50) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_eq("reach_a_yel", m_ph[0], 1);
    reset_pulse();
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Both streets busy: alternate with maximum greens.
    for (int i = 0; i < 110; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // A held green for a long time; narrow timer must saturate, not wrap.
    reset_pulse();
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Preempt toward B one cycle into A green, held with A traffic present.
    reset_pulse();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);

    // Random traffic, preempts and occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      bit a  = ($urandom_range(0, 3) != 0);
      bit b  = ($urandom_range(0, 3) != 0);
      bit er = ($urandom_range(0, 9) == 0);
      bit ed = $urandom_range(0, 1) != 0;
      cycle(a, b, er, ed);
      if ($urandom_range(0, 149) == 0) reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
